// File: rtl/half_sum_serial_ctrl.sv
// Bit-serial WIDTH-bit adder that reuses one half adder twice per bit, LSB first.
// Optional subtract mode is enabled by defining HALF_SUM_SERIAL_SUB_EN.

module half_sum_func (
    input  logic a,
    input  logic b,
    output logic s,
    output logic cout
);
    assign s    = a ^ b;
    assign cout = a & b;
endmodule

module half_sum_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef HALF_SUM_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg, s1_reg, c1_reg, cout_reg;

    logic             ha_a, ha_b, q_s, q_cout;
    logic             last_bit;
    logic [WIDTH-1:0] res_wr;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef HALF_SUM_SERIAL_SUB_EN
    // Two's-complement subtract: A + ~B + 1
    assign b_load     = sub ? ~b_in : b_in;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b_in;
    assign carry_load = cin;
`endif

    half_sum_func u_ha (
        .a    (ha_a),
        .b    (ha_b),
        .s    (q_s),
        .cout (q_cout)
    );

    // One-hot mask selects the current bit, so no counter arithmetic is needed
    assign last_bit = mask_reg[WIDTH-1];
    assign res_wr   = (res_reg & ~mask_reg) | (q_s ? mask_reg : '0);

    always_comb begin
        state_next = state_reg;
        ha_a       = 1'b0;
        ha_b       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = PH1;
            end
            PH1: begin
                ha_a       = |(a_reg & mask_reg);
                ha_b       = |(b_reg & mask_reg);
                state_next = PH2;
            end
            PH2: begin
                ha_a       = s1_reg;
                ha_b       = carry_reg;
                state_next = last_bit ? DONE : PH1;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            mask_reg  <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            s1_reg    <= 1'b0;
            c1_reg    <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_load;
                        carry_reg <= carry_load;
                        mask_reg  <= WIDTH'(1);
                        res_reg   <= '0;
                    end
                end
                PH1: begin
                    s1_reg <= q_s;
                    c1_reg <= q_cout;
                end
                PH2: begin
                    res_reg   <= res_wr;
                    carry_reg <= c1_reg | q_cout;
                    if (last_bit) begin
                        sum_reg  <= res_wr;
                        cout_reg <= c1_reg | q_cout;
                    end else begin
                        mask_reg <= mask_reg << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_reg == IDLE);
    assign done  = (state_reg == DONE);
    assign sum   = sum_reg;
    assign cout  = cout_reg;

endmodule

// File: tb/tb_half_sum_serial_ctrl.sv
// Randomized self-checking bench for half_sum_serial_ctrl (WIDTH=8) against an
// arithmetic reference; exercises subtract mode when HALF_SUM_SERIAL_SUB_EN is defined.

module tb_half_sum_serial_ctrl;
    localparam int WIDTH = 8;
    localparam int LAT   = 2 * WIDTH;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic             cin;
    logic             sub;
    logic             ready, done, cout;
    logic [WIDTH-1:0] sum;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;
    int last_acc = 0;
    logic [WIDTH:0] prev_res = '0;

    half_sum_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
`ifdef HALF_SUM_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // mode 0: start pulsed once; 1: start held with random operands while busy;
    // 2: start left high after done (back-to-back)
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic sb, input int mode);
        int w;
        int lat;
        int acc;
        bit hold_ok;
        logic [WIDTH:0] exp;
        w = 0;
        while (!ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_op", 32'(ready), 32'd1);
        a_in = a; b_in = b; cin = c; sub = sb; start = 1'b1;
        if (sb) exp = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
        @(posedge clk);
        acc = cyc;
        if (mode == 2 && last_acc != 0)
            check("accept_interval", 32'(acc - last_acc), 32'(LAT + 2));
        last_acc = acc;
        lat = 0;
        hold_ok = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            if (done) break;
            if ({cout, sum} !== prev_res) hold_ok = 1'b0;
            if (mode == 0) start = 1'b0;
            if (mode == 1) begin
                start = 1'b1;
                a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
                sub = 1'($urandom);
            end
            @(posedge clk);
            lat++;
        end
        if (mode != 2) start = 1'b0;
        $display("op a=0x%02h b=0x%02h cin=%0d sub=%0d mode=%0d -> sum=0x%02h cout=%0d lat=%0d",
                 a, b, c, sb, mode, sum, cout, lat);
        check("latency", 32'(lat), 32'(LAT));
        check("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
        check("cout", 32'(cout), 32'(exp[WIDTH]));
        check("outputs_held_while_busy", 32'(hold_ok), 32'd1);
        prev_res = exp;
        @(posedge clk);
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1);

        // abort mid-operation with reset
        a_in = 8'h0F; b_in = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        prev_res = '0;
        @(negedge clk);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);

`ifdef HALF_SUM_SERIAL_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0);
`endif

        last_acc = 0;
        for (int k = 0; k < 3; k++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 2);
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 16; k++) begin
`ifdef HALF_SUM_SERIAL_SUB_EN
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
`else
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 1)));
`endif
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/half_sum_serial_ctrl.md
Name: half_sum_serial_ctrl

Overview:
- Sequencer that time-shares ONE internal half_sum_func instance to perform a WIDTH-bit add, LSB first, two half-adder passes per bit.
- Each bit is a full add built from two half-adder passes plus carry merge (carry = c1 | c2).
- Replaces a WIDTH-wide ripple of gates where area matters more than latency.
- start/ready/done handshake toward the requester.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in a cycle where ready=1
a_in  input  WIDTH  operand A; sampled on accept edge only
b_in  input  WIDTH  operand B; sampled on accept edge only
cin  input  1  carry-in; sampled on accept edge only
ready  output  1  1 in IDLE only
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  registered result; holds until the next completion
cout  output  1  registered carry-out; holds like sum

Behaviour:
- Reset (rst_n=0, async), all registers cleared: state=IDLE, ready=1, done=0, sum=0, cout=0, bit index=0, internal carry/operand/temp registers=0.
- States:
  - IDLE: ready=1. start=1 -> latch a_in/b_in into shift registers, carry<=cin, idx<=0, go to PH1.
  - PH1: drive HA with (a[idx], b[idx]); register s1<=qS, c1<=qCout; go to PH2.
  - PH2: drive HA with (s1, carry); write qS into result bit idx; carry<=c1|qCout.
    - idx==WIDTH-1 -> go to DONE.
    - Otherwise idx<=idx+1, go to PH1.
  - DONE: done=1 for exactly this cycle; sum/cout were loaded on the PH2->DONE edge; unconditional return to IDLE.
- The HA is the only adder logic in the block; no '+' operator anywhere in the datapath.
- HA inputs are muxed by state; in IDLE/DONE they are driven to 0.
- Latency:
  - Accept edge = edge 0.
  - done is high in the cycle after edge 2*WIDTH.
  - ready returns after edge 2*WIDTH+1.
  - Throughput: one operation per 2*WIDTH+2 cycles.
- start while not in IDLE (PH1/PH2/DONE): ignored, no queuing; operand inputs may change freely.
- sum/cout change only on the PH2->DONE edge or reset; intermediate bits never appear on sum.
- Result width rule: {cout,sum} = a_in + b_in + cin, modulo 2^(WIDTH+1), exact.
- Reset mid-operation: operation aborted, no done pulse, outputs cleared to 0, IDLE after release.
- WIDTH=1: PH1, PH2, DONE, then IDLE; done in the cycle after edge 2.

Optional Feature:
- Macro: HALF_SUM_SERIAL_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1: B is latched inverted (~b_in) and carry<=1, ignoring cin. Result = a_in - b_in mod 2^WIDTH.
  - cout=1 means no borrow (a_in >= b_in unsigned).
  - sub=0: identical to the base add.
- Undefined: port sub absent; add-only behaviour exactly as above.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, pulse start -> done exactly 16 cycles after the accept edge, sum=0x96, cout=0, ready back next cycle.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Accept a=0x01, b=0x01; at cycle 5 assert start with a=0x80, b=0x80, and change a_in/b_in -> single done, sum=0x02, cout=0, no second operation.
- Accept a=0x0F, b=0x01; drop rst_n at cycle 7 for 2 cycles -> no done, sum=0x00, cout=0, ready=1 immediately; next op a=0x0F, b=0x01 -> sum=0x10.
- Macro defined: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
- Back-to-back: start held high continuously with three operand sets -> one accept per 18 cycles, each result matches the reference sum, done never high for 2 consecutive cycles.
